reservation_station: RTL and testbench

- Receiving end of the decoder's issue interface for ALU-class ops (arith, branch, jump, LUI/AUIPC).
- Buffers issued ops in a fixed pool of entries and snoops the ALU and LSB result broadcasts to resolve operand dependencies.
- Dispatches one fully-ready op per cycle to the ALU.
- Back-pressures the decoder through rs_full.

---
 rtl/reservation_station_pkg.sv | 51 +++++
 rtl/reservation_station_rs_priority_pick.sv | 24 ++
 rtl/reservation_station.sv | 232 +++++++++++++++++++++++
 tb/tb_reservation_station.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared definitions for the ALU reservation station: sizing constants,
// decoded op encodings and the reserved "no dependency" ROB tag.
package reservation_station_pkg;

  localparam int RS_SIZE         = 16;
  localparam int RS_INDEX_WIDTH  = 4;
  localparam int ROB_INDEX_WIDTH = 4;
  localparam int DATA_WIDTH      = 32;
  localparam int OPENUM_WIDTH    = 6;

  // ROB tag 0 is never allocated, so a depend of 0 marks an operand as ready.
  localparam logic [ROB_INDEX_WIDTH-1:0] NO_DEPEND = 4'd0;

  // Free entries below this count raise rs_full (one slot of margin for the
  // decoder's issue pipeline).
  localparam logic [RS_INDEX_WIDTH:0] FULL_MARGIN = 5'd2;

  typedef enum logic [OPENUM_WIDTH-1:0] {
    OPENUM_NOP   = 6'd0,
    OPENUM_LUI   = 6'd1,
    OPENUM_AUIPC = 6'd2,
    OPENUM_JAL   = 6'd3,
    OPENUM_JALR  = 6'd4,
    OPENUM_BEQ   = 6'd5,
    OPENUM_BNE   = 6'd6,
    OPENUM_BLT   = 6'd7,
    OPENUM_BGE   = 6'd8,
    OPENUM_BLTU  = 6'd9,
    OPENUM_BGEU  = 6'd10,
    OPENUM_ADDI  = 6'd11,
    OPENUM_SLTI  = 6'd12,
    OPENUM_SLTIU = 6'd13,
    OPENUM_XORI  = 6'd14,
    OPENUM_ORI   = 6'd15,
    OPENUM_ANDI  = 6'd16,
    OPENUM_SLLI  = 6'd17,
    OPENUM_SRLI  = 6'd18,
    OPENUM_SRAI  = 6'd19,
    OPENUM_ADD   = 6'd20,
    OPENUM_SUB   = 6'd21,
    OPENUM_SLL   = 6'd22,
    OPENUM_SLT   = 6'd23,
    OPENUM_SLTU  = 6'd24,
    OPENUM_XOR   = 6'd25,
    OPENUM_SRL   = 6'd26,
    OPENUM_SRA   = 6'd27,
    OPENUM_OR    = 6'd28,
    OPENUM_AND   = 6'd29
  } openum_t;

endpackage

// File: rtl/reservation_station_rs_priority_pick.sv
// Lowest-index picker: given a request vector, returns the lowest set bit as
// a one-hot vector and as a binary index, plus a flag telling whether any
// request was set. Used for both free-slot and ready-entry selection.
module rs_priority_pick #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Isolate the lowest set bit and encode its position.
  always_comb begin
    onehot = req & (~req + {{(N-1){1'b0}}, 1'b1});
    found  = |req;
    idx    = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx = idx | (onehot[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for ALU-class ops. Buffers issued ops, snoops the ALU
// and LSB result broadcasts to resolve operand tags, and dispatches the
// lowest-index fully ready op to the ALU each cycle.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clr_in,

  input  logic                       issue_ready,
  input  logic                       issue_rs_ready,
  input  logic [ROB_INDEX_WIDTH-1:0] issue_rob_index,
  input  logic [OPENUM_WIDTH-1:0]    issue_op,
  input  logic [DATA_WIDTH-1:0]      issue_rs1_val,
  input  logic [DATA_WIDTH-1:0]      issue_rs2_val,
  input  logic [ROB_INDEX_WIDTH-1:0] issue_rs1_depend,
  input  logic [ROB_INDEX_WIDTH-1:0] issue_rs2_depend,
  input  logic [DATA_WIDTH-1:0]      issue_imm,
  input  logic [DATA_WIDTH-1:0]      issue_PC,

  output logic                       rs_full,

  input  logic                       alu_ready,
  input  logic [ROB_INDEX_WIDTH-1:0] alu_rob_index,
  input  logic [DATA_WIDTH-1:0]      alu_result,

  input  logic                       lsb_ready,
  input  logic [ROB_INDEX_WIDTH-1:0] lsb_rob_index,
  input  logic [DATA_WIDTH-1:0]      lsb_result,

  output logic                       rs_to_alu_valid,
  output logic [OPENUM_WIDTH-1:0]    rs_to_alu_op,
  output logic [DATA_WIDTH-1:0]      rs_to_alu_rs1_val,
  output logic [DATA_WIDTH-1:0]      rs_to_alu_rs2_val,
  output logic [DATA_WIDTH-1:0]      rs_to_alu_imm,
  output logic [DATA_WIDTH-1:0]      rs_to_alu_PC,
  output logic [ROB_INDEX_WIDTH-1:0] rs_to_alu_rob_index
);

  // Entry storage
  logic [RS_SIZE-1:0]         busy_r;
  logic [OPENUM_WIDTH-1:0]    op_r      [RS_SIZE];
  logic [DATA_WIDTH-1:0]      rs1_val_r [RS_SIZE];
  logic [DATA_WIDTH-1:0]      rs2_val_r [RS_SIZE];
  logic [ROB_INDEX_WIDTH-1:0] rs1_dep_r [RS_SIZE];
  logic [ROB_INDEX_WIDTH-1:0] rs2_dep_r [RS_SIZE];
  logic [DATA_WIDTH-1:0]      imm_r     [RS_SIZE];
  logic [DATA_WIDTH-1:0]      pc_r      [RS_SIZE];
  logic [ROB_INDEX_WIDTH-1:0] rob_r     [RS_SIZE];

  // Selection and bookkeeping
  logic [RS_SIZE-1:0]         free_vec_s;
  logic [RS_SIZE-1:0]         ready_vec_s;
  logic [RS_SIZE-1:0]         free_onehot_s;
  logic [RS_SIZE-1:0]         ready_onehot_s;
  logic [RS_INDEX_WIDTH-1:0]  free_idx_s;
  logic [RS_INDEX_WIDTH-1:0]  ready_idx_s;
  logic                       free_found_s;
  logic                       ready_found_s;
  logic [RS_INDEX_WIDTH:0]    free_count_s;
  logic                       issue_write_s;
  logic [RS_SIZE-1:0]         busy_next_s;

  // Issue-time operand capture (same-cycle broadcast bypass)
  logic [DATA_WIDTH-1:0]      issue_rs1_val_s;
  logic [DATA_WIDTH-1:0]      issue_rs2_val_s;
  logic [ROB_INDEX_WIDTH-1:0] issue_rs1_dep_s;
  logic [ROB_INDEX_WIDTH-1:0] issue_rs2_dep_s;

  // A broadcast resolves a waiting operand only for a real (nonzero) tag.
  function automatic logic tag_hit(
    input logic [ROB_INDEX_WIDTH-1:0] dep,
    input logic                       bvalid,
    input logic [ROB_INDEX_WIDTH-1:0] btag
  );
    return bvalid && (btag != NO_DEPEND) && (btag == dep);
  endfunction

  // Build free/ready request vectors and count free entries.
  always_comb begin
    free_vec_s   = {RS_SIZE{1'b0}};
    ready_vec_s  = {RS_SIZE{1'b0}};
    free_count_s = {(RS_INDEX_WIDTH+1){1'b0}};
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec_s[i]  = ~busy_r[i];
      ready_vec_s[i] = busy_r[i] && (rs1_dep_r[i] == NO_DEPEND) &&
                       (rs2_dep_r[i] == NO_DEPEND);
      free_count_s   = free_count_s + {{RS_INDEX_WIDTH{1'b0}}, free_vec_s[i]};
    end
  end

  rs_priority_pick #(
    .N     (RS_SIZE),
    .IDX_W (RS_INDEX_WIDTH)
  ) u_free_pick (
    .req    (free_vec_s),
    .onehot (free_onehot_s),
    .idx    (free_idx_s),
    .found  (free_found_s)
  );

  rs_priority_pick #(
    .N     (RS_SIZE),
    .IDX_W (RS_INDEX_WIDTH)
  ) u_ready_pick (
    .req    (ready_vec_s),
    .onehot (ready_onehot_s),
    .idx    (ready_idx_s),
    .found  (ready_found_s)
  );

  assign rs_full = (free_count_s < FULL_MARGIN);

  // Decide whether an issue is written and the resulting busy vector.
  always_comb begin
    issue_write_s = issue_ready && issue_rs_ready && free_found_s;
    busy_next_s   = busy_r & ~ready_onehot_s;
    if (issue_write_s) begin
      busy_next_s = busy_next_s | free_onehot_s;
    end else begin
      busy_next_s = busy_next_s;
    end
  end

  // Resolve issued operands against this cycle's broadcasts (ALU first).
  always_comb begin
    issue_rs1_val_s = issue_rs1_val;
    issue_rs1_dep_s = issue_rs1_depend;
    issue_rs2_val_s = issue_rs2_val;
    issue_rs2_dep_s = issue_rs2_depend;
    if (tag_hit(issue_rs1_depend, alu_ready, alu_rob_index)) begin
      issue_rs1_val_s = alu_result;
      issue_rs1_dep_s = NO_DEPEND;
    end else if (tag_hit(issue_rs1_depend, lsb_ready, lsb_rob_index)) begin
      issue_rs1_val_s = lsb_result;
      issue_rs1_dep_s = NO_DEPEND;
    end else begin
      issue_rs1_dep_s = issue_rs1_depend;
    end
    if (tag_hit(issue_rs2_depend, alu_ready, alu_rob_index)) begin
      issue_rs2_val_s = alu_result;
      issue_rs2_dep_s = NO_DEPEND;
    end else if (tag_hit(issue_rs2_depend, lsb_ready, lsb_rob_index)) begin
      issue_rs2_val_s = lsb_result;
      issue_rs2_dep_s = NO_DEPEND;
    end else begin
      issue_rs2_dep_s = issue_rs2_depend;
    end
  end

  // Entry state: flush, wakeup, issue write and dispatch register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_r              <= {RS_SIZE{1'b0}};
      rs_to_alu_valid     <= 1'b0;
      rs_to_alu_op        <= {OPENUM_WIDTH{1'b0}};
      rs_to_alu_rs1_val   <= {DATA_WIDTH{1'b0}};
      rs_to_alu_rs2_val   <= {DATA_WIDTH{1'b0}};
      rs_to_alu_imm       <= {DATA_WIDTH{1'b0}};
      rs_to_alu_PC        <= {DATA_WIDTH{1'b0}};
      rs_to_alu_rob_index <= {ROB_INDEX_WIDTH{1'b0}};
      for (int i = 0; i < RS_SIZE; i++) begin
        op_r[i]      <= {OPENUM_WIDTH{1'b0}};
        rs1_val_r[i] <= {DATA_WIDTH{1'b0}};
        rs2_val_r[i] <= {DATA_WIDTH{1'b0}};
        rs1_dep_r[i] <= NO_DEPEND;
        rs2_dep_r[i] <= NO_DEPEND;
        imm_r[i]     <= {DATA_WIDTH{1'b0}};
        pc_r[i]      <= {DATA_WIDTH{1'b0}};
        rob_r[i]     <= {ROB_INDEX_WIDTH{1'b0}};
      end
    end else if (rdy_in) begin
      if (clr_in) begin
        busy_r          <= {RS_SIZE{1'b0}};
        rs_to_alu_valid <= 1'b0;
      end else begin
        busy_r <= busy_next_s;

        // Wakeup of waiting operands in busy entries.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_r[i] && (rs1_dep_r[i] != NO_DEPEND)) begin
            if (tag_hit(rs1_dep_r[i], alu_ready, alu_rob_index)) begin
              rs1_val_r[i] <= alu_result;
              rs1_dep_r[i] <= NO_DEPEND;
            end else if (tag_hit(rs1_dep_r[i], lsb_ready, lsb_rob_index)) begin
              rs1_val_r[i] <= lsb_result;
              rs1_dep_r[i] <= NO_DEPEND;
            end
          end
          if (busy_r[i] && (rs2_dep_r[i] != NO_DEPEND)) begin
            if (tag_hit(rs2_dep_r[i], alu_ready, alu_rob_index)) begin
              rs2_val_r[i] <= alu_result;
              rs2_dep_r[i] <= NO_DEPEND;
            end else if (tag_hit(rs2_dep_r[i], lsb_ready, lsb_rob_index)) begin
              rs2_val_r[i] <= lsb_result;
              rs2_dep_r[i] <= NO_DEPEND;
            end
          end
        end

        // Issue into the lowest free entry; it is never a busy entry, so it
        // cannot collide with the wakeup writes above.
        if (issue_write_s) begin
          op_r[free_idx_s]      <= issue_op;
          rs1_val_r[free_idx_s] <= issue_rs1_val_s;
          rs2_val_r[free_idx_s] <= issue_rs2_val_s;
          rs1_dep_r[free_idx_s] <= issue_rs1_dep_s;
          rs2_dep_r[free_idx_s] <= issue_rs2_dep_s;
          imm_r[free_idx_s]     <= issue_imm;
          pc_r[free_idx_s]      <= issue_PC;
          rob_r[free_idx_s]     <= issue_rob_index;
        end

        // Dispatch the lowest ready entry; payload holds when idle.
        if (ready_found_s) begin
          rs_to_alu_valid     <= 1'b1;
          rs_to_alu_op        <= op_r[ready_idx_s];
          rs_to_alu_rs1_val   <= rs1_val_r[ready_idx_s];
          rs_to_alu_rs2_val   <= rs2_val_r[ready_idx_s];
          rs_to_alu_imm       <= imm_r[ready_idx_s];
          rs_to_alu_PC        <= pc_r[ready_idx_s];
          rs_to_alu_rob_index <= rob_r[ready_idx_s];
        end else begin
          rs_to_alu_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios followed by
// randomized traffic, all compared against a slot-level behavioural model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic        issue_ready, issue_rs_ready;
  logic [3:0]  issue_rob_index, issue_rs1_depend, issue_rs2_depend;
  logic [5:0]  issue_op;
  logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_PC;
  logic        rs_full;
  logic        alu_ready, lsb_ready;
  logic [3:0]  alu_rob_index, lsb_rob_index;
  logic [31:0] alu_result, lsb_result;
  logic        rs_to_alu_valid;
  logic [5:0]  rs_to_alu_op;
  logic [31:0] rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_PC;
  logic [3:0]  rs_to_alu_rob_index;

  always #5 clk_in = ~clk_in;

  reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .issue_ready(issue_ready), .issue_rs_ready(issue_rs_ready),
    .issue_rob_index(issue_rob_index), .issue_op(issue_op),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_rs1_depend(issue_rs1_depend), .issue_rs2_depend(issue_rs2_depend),
    .issue_imm(issue_imm), .issue_PC(issue_PC), .rs_full(rs_full),
    .alu_ready(alu_ready), .alu_rob_index(alu_rob_index), .alu_result(alu_result),
    .lsb_ready(lsb_ready), .lsb_rob_index(lsb_rob_index), .lsb_result(lsb_result),
    .rs_to_alu_valid(rs_to_alu_valid), .rs_to_alu_op(rs_to_alu_op),
    .rs_to_alu_rs1_val(rs_to_alu_rs1_val), .rs_to_alu_rs2_val(rs_to_alu_rs2_val),
    .rs_to_alu_imm(rs_to_alu_imm), .rs_to_alu_PC(rs_to_alu_PC),
    .rs_to_alu_rob_index(rs_to_alu_rob_index)
  );

  // Reference model: one record per slot plus the expected dispatch register.
  bit          m_busy [16];
  logic [5:0]  m_op   [16];
  logic [31:0] m_v1 [16], m_v2 [16], m_imm [16], m_pc [16];
  logic [3:0]  m_d1 [16], m_d2 [16], m_rob [16];
  bit          e_valid;
  logic [5:0]  e_op;
  logic [31:0] e_v1, e_v2, e_imm, e_pc;
  logic [3:0]  e_rob;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit hit(input logic [3:0] dep, input logic v, input logic [3:0] t);
    return v && (t != 4'd0) && (t == dep);
  endfunction

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < 16; i++) if (!m_busy[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_busy[i] = 1'b0; m_d1[i] = 4'd0; m_d2[i] = 4'd0;
    end
    e_valid = 1'b0; e_op = 6'd0; e_v1 = 32'd0; e_v2 = 32'd0;
    e_imm = 32'd0; e_pc = 32'd0; e_rob = 4'd0;
  endtask

  // Apply the spec's per-edge rules to the model using the current inputs.
  task automatic model_edge();
    int d = -1;
    int f = -1;
    logic [31:0] v;
    logic [3:0]  dp;
    if (rst_in) begin model_reset(); return; end
    if (!rdy_in) return;
    if (clr_in) begin
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      e_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 16; i++) begin
      if (d < 0 && m_busy[i] && m_d1[i] == 4'd0 && m_d2[i] == 4'd0) d = i;
      if (f < 0 && !m_busy[i]) f = i;
    end
    for (int i = 0; i < 16; i++) begin
      if (m_busy[i]) begin
        if (hit(m_d1[i], alu_ready, alu_rob_index)) begin m_v1[i] = alu_result; m_d1[i] = 4'd0; end
        else if (hit(m_d1[i], lsb_ready, lsb_rob_index)) begin m_v1[i] = lsb_result; m_d1[i] = 4'd0; end
        if (hit(m_d2[i], alu_ready, alu_rob_index)) begin m_v2[i] = alu_result; m_d2[i] = 4'd0; end
        else if (hit(m_d2[i], lsb_ready, lsb_rob_index)) begin m_v2[i] = lsb_result; m_d2[i] = 4'd0; end
      end
    end
    if (d >= 0) begin
      e_valid = 1'b1; e_op = m_op[d]; e_v1 = m_v1[d]; e_v2 = m_v2[d];
      e_imm = m_imm[d]; e_pc = m_pc[d]; e_rob = m_rob[d];
      m_busy[d] = 1'b0;
    end else begin
      e_valid = 1'b0;
    end
    if (issue_ready && issue_rs_ready && f >= 0) begin
      m_busy[f] = 1'b1; m_op[f] = issue_op; m_imm[f] = issue_imm;
      m_pc[f] = issue_PC; m_rob[f] = issue_rob_index;
      v = issue_rs1_val; dp = issue_rs1_depend;
      if (hit(dp, alu_ready, alu_rob_index)) begin v = alu_result; dp = 4'd0; end
      else if (hit(dp, lsb_ready, lsb_rob_index)) begin v = lsb_result; dp = 4'd0; end
      m_v1[f] = v; m_d1[f] = dp;
      v = issue_rs2_val; dp = issue_rs2_depend;
      if (hit(dp, alu_ready, alu_rob_index)) begin v = alu_result; dp = 4'd0; end
      else if (hit(dp, lsb_ready, lsb_rob_index)) begin v = lsb_result; dp = 4'd0; end
      m_v2[f] = v; m_d2[f] = dp;
    end
  endtask

  task automatic compare_all();
    check_eq("valid", rs_to_alu_valid, e_valid);
    check_eq("rs_full", rs_full, (model_free() < 2));
    if (e_valid) begin
      check_eq("rob", rs_to_alu_rob_index, e_rob);
      check_eq("op", rs_to_alu_op, e_op);
      check_eq("rs1", rs_to_alu_rs1_val, e_v1);
      check_eq("rs2", rs_to_alu_rs2_val, e_v2);
      check_eq("imm", rs_to_alu_imm, e_imm);
      check_eq("pc", rs_to_alu_PC, e_pc);
    end
  endtask

  // One clock: update model, take the edge, compare at the falling edge,
  // then drop the one-shot inputs.
  task automatic step();
    model_edge();
    @(posedge clk_in);
    @(negedge clk_in);
    compare_all();
    issue_ready = 1'b0; issue_rs_ready = 1'b0;
    alu_ready = 1'b0; lsb_ready = 1'b0; clr_in = 1'b0;
  endtask

  task automatic put_issue(input logic [3:0] rob, input logic [5:0] op,
                           input logic [31:0] v1, input logic [3:0] d1,
                           input logic [31:0] v2, input logic [3:0] d2,
                           input logic [31:0] imm, input logic [31:0] pc);
    issue_ready = 1'b1; issue_rs_ready = 1'b1; issue_rob_index = rob; issue_op = op;
    issue_rs1_val = v1; issue_rs1_depend = d1; issue_rs2_val = v2;
    issue_rs2_depend = d2; issue_imm = imm; issue_PC = pc;
  endtask

  task automatic bcast_alu(input logic [3:0] t, input logic [31:0] r);
    alu_ready = 1'b1; alu_rob_index = t; alu_result = r;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0;
    alu_ready = 1'b0; lsb_ready = 1'b0; alu_rob_index = 4'd0; lsb_rob_index = 4'd0;
    alu_result = 32'd0; lsb_result = 32'd0;
    put_issue(4'd1, OPENUM_ADD, 32'd1, 4'd0, 32'd2, 4'd0, 32'd0, 32'd0);
    model_reset();

    // Reset held with an issue pending: nothing may enter the pool.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check_eq("rst_valid", rs_to_alu_valid, 1'b0);
      check_eq("rst_full", rs_full, 1'b0);
    end
    rst_in = 1'b0; issue_ready = 1'b0; issue_rs_ready = 1'b0;
    step();

    // Ready op: dispatched on the second edge after issue, one-cycle pulse.
    put_issue(4'd3, OPENUM_ADD, 32'd5, 4'd0, 32'd7, 4'd0, 32'd0, 32'h100);
    step();
    check_eq("add_early", rs_to_alu_valid, 1'b0);
    step();
    check_eq("add_valid", rs_to_alu_valid, 1'b1);
    check_eq("add_rob", rs_to_alu_rob_index, 4'd3);
    check_eq("add_rs1", rs_to_alu_rs1_val, 32'd5);
    check_eq("add_rs2", rs_to_alu_rs2_val, 32'd7);
    step();
    check_eq("add_pulse", rs_to_alu_valid, 1'b0);

    // Wakeup by a later ALU broadcast.
    put_issue(4'd2, OPENUM_SUB, 32'd0, 4'd4, 32'd11, 4'd0, 32'd0, 32'h104);
    step(); step(); step();
    bcast_alu(4'd4, 32'h1234);
    step();
    check_eq("wake_wait", rs_to_alu_valid, 1'b0);
    step();
    check_eq("wake_valid", rs_to_alu_valid, 1'b1);
    check_eq("wake_rs1", rs_to_alu_rs1_val, 32'h1234);
    step();

    // LSB broadcast on the issue cycle: behaves like a ready issue.
    put_issue(4'd6, OPENUM_XOR, 32'd0, 4'd5, 32'd0, 4'd0, 32'd0, 32'h108);
    lsb_ready = 1'b1; lsb_rob_index = 4'd5; lsb_result = 32'hBEEF;
    bcast_alu(4'd7, 32'h5555);
    step(); step();
    check_eq("bypass_valid", rs_to_alu_valid, 1'b1);
    check_eq("bypass_rs1", rs_to_alu_rs1_val, 32'hBEEF);
    step();

    // Fill the pool with ops blocked on tag 9.
    for (int k = 0; k < 16; k++) begin
      put_issue(4'((k % 15) + 1), OPENUM_ADD, 32'd0, 4'd9, 32'(k), 4'd0, 32'(k), 32'(k * 4));
      step();
      if (k == 13) check_eq("full_at14", rs_full, 1'b0);
      if (k == 14) check_eq("full_at15", rs_full, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("stuck_full", rs_full, 1'b1);
    end
    bcast_alu(4'd9, 32'hAAAA0000);
    step();
    for (int k = 0; k < 16; k++) begin
      step();
      check_eq("drain_valid", rs_to_alu_valid, 1'b1);
      check_eq("drain_order", rs_to_alu_imm, 32'(k));
    end
    step();
    check_eq("drain_full", rs_full, 1'b0);

    // Flush discards blocked entries and a same-cycle issue.
    for (int k = 0; k < 4; k++) begin
      put_issue(4'd1, OPENUM_OR, 32'd0, 4'd11, 32'd0, 4'd0, 32'(k), 32'd0);
      step();
    end
    clr_in = 1'b1;
    put_issue(4'd2, OPENUM_OR, 32'd1, 4'd0, 32'd1, 4'd0, 32'hF, 32'd0);
    step();
    bcast_alu(4'd11, 32'd99);
    step(); step(); step();
    check_eq("clr_valid", rs_to_alu_valid, 1'b0);
    check_eq("clr_full", rs_full, 1'b0);

    // Freeze with rdy_in low while a wakeup is pending.
    put_issue(4'd1, OPENUM_AND, 32'd0, 4'd12, 32'd3, 4'd0, 32'hA, 32'd0);
    step();
    put_issue(4'd2, OPENUM_AND, 32'd0, 4'd13, 32'd4, 4'd0, 32'hB, 32'd0);
    step();
    bcast_alu(4'd12, 32'h77);
    step();
    for (int k = 0; k < 5; k++) begin
      rdy_in = 1'b0;
      bcast_alu(4'd13, 32'h88);
      step();
      check_eq("freeze_valid", rs_to_alu_valid, 1'b0);
    end
    rdy_in = 1'b1;
    step();
    check_eq("thaw_valid", rs_to_alu_valid, 1'b1);
    check_eq("thaw_imm", rs_to_alu_imm, 32'hA);
    step();
    check_eq("thaw_blocked", rs_to_alu_valid, 1'b0);
    lsb_ready = 1'b1; lsb_rob_index = 4'd13; lsb_result = 32'h99;
    step(); step();
    check_eq("thaw_b_imm", rs_to_alu_imm, 32'hB);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      clr_in = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 6) begin
        put_issue(4'($urandom_range(1, 15)), 6'($urandom_range(0, 29)),
                  $urandom, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                  $urandom, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                  $urandom, $urandom);
        issue_rs_ready = ($urandom_range(0, 9) != 0) && (model_free() > 0);
      end
      alu_ready = ($urandom_range(0, 9) < 4);
      alu_rob_index = 4'($urandom_range(0, 15));
      alu_result = $urandom;
      lsb_ready = ($urandom_range(0, 9) < 4);
      lsb_rob_index = 4'($urandom_range(0, 15));
      lsb_result = $urandom;
      if (alu_ready && lsb_ready && alu_rob_index == lsb_rob_index) lsb_ready = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
